// File: rtl/serpent_key_manager.sv
// -----------------------------------------------------------------------------
// serpent_key_manager
//   Drives the shared Serpent subkey-schedule datapath twice per load: first
//   with K1 (data key), then with K2 (tweak key). It captures 2 x NUM_SUBKEYS
//   128-bit subkeys into an internal store (bank0 = K1, bank1 = K2). Once both
//   banks are complete, a single store read port is shared round-robin between
//   the data cipher (req 0, bank0) and the tweak cipher (req 1, bank1).
//
// Ports
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_load               pulse: latch i_key1/i_key2 and start scheduling
//   i_key1, i_key2       data key K1, tweak key K2
//   o_busy               scheduling in progress
//   o_keys_ready         both banks complete and readable
//   o_error              sticky: a schedule pass timed out
//   o_ks_begin           1-cycle start pulse to the schedule datapath
//   o_ks_key             key for the current pass, held for the whole pass
//   i_ks_subkey/_address/_valid  subkey writes from the datapath
//   i_req, i_req_idx0/1  read requests and their subkey indices
//   o_gnt                one-hot grant
//   o_rd_valid/_data/_id read return, one cycle after the grant
// -----------------------------------------------------------------------------
module serpent_key_manager #(
    parameter int unsigned NUM_SUBKEYS = 33,
    parameter int unsigned KS_TIMEOUT  = 64
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_load,
    input  logic [255:0] i_key1,
    input  logic [255:0] i_key2,
    output logic         o_busy,
    output logic         o_keys_ready,
    output logic         o_error,
    output logic         o_ks_begin,
    output logic [255:0] o_ks_key,
    input  logic [127:0] i_ks_subkey,
    input  logic [5:0]   i_ks_address,
    input  logic         i_ks_subkey_valid,
    input  logic [1:0]   i_req,
    input  logic [5:0]   i_req_idx0,
    input  logic [5:0]   i_req_idx1,
    output logic [1:0]   o_gnt,
    output logic         o_rd_valid,
    output logic [127:0] o_rd_data,
    output logic         o_rd_id
);
    localparam int unsigned STORE_DEPTH = 2 * NUM_SUBKEYS;
    localparam int unsigned CNT_W       = $clog2(KS_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START1,
        S_RUN1,
        S_START2,
        S_RUN2
    } state_t;

    state_t                 state_q, state_d;
    logic [255:0]           key1_q, key2_q;
    logic [NUM_SUBKEYS-1:0] mask_q, wr_mask;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ready_q, error_q, rr_q;
    logic [127:0]           store [STORE_DEPTH];

    logic                   in_run, wr_hit, mask_full, timeout;
    logic [6:0]             wr_idx, rd_idx;
    logic [5:0]             rd_sub;
    logic                   rd_in_range;
    logic [1:0]             gnt;
    logic                   rd_valid_q, rd_id_q;
    logic [127:0]           rd_data_q;

    // Capture decode. Completion looks at the mask including this cycle's
    // write, so the pass ends on the same edge as its last new address.
    always_comb begin
        in_run    = (state_q == S_RUN1) || (state_q == S_RUN2);
        wr_hit    = in_run && i_ks_subkey_valid &&
                    ({1'b0, i_ks_address} < 7'(NUM_SUBKEYS));
        wr_mask   = '0;
        if (wr_hit) begin
            wr_mask[i_ks_address] = 1'b1;
        end
        mask_full = &(mask_q | wr_mask);
        timeout   = (cnt_q == CNT_W'(KS_TIMEOUT - 1));
        wr_idx    = ((state_q == S_RUN2) ? 7'(NUM_SUBKEYS) : 7'd0) + {1'b0, i_ks_address};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (i_load) state_d = S_START1;
            S_START1: state_d = S_RUN1;
            S_RUN1:   if (mask_full) state_d = S_START2;
                      else if (timeout) state_d = S_IDLE;
            S_START2: state_d = S_RUN2;
            S_RUN2:   if (mask_full || timeout) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            key1_q  <= '0;
            key2_q  <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: begin
                    if (i_load) begin
                        key1_q  <= i_key1;
                        key2_q  <= i_key2;
                        ready_q <= 1'b0;
                        error_q <= 1'b0;
                        mask_q  <= '0;
                    end
                end
                S_START1, S_START2: begin
                    cnt_q  <= '0;
                    mask_q <= '0;
                end
                S_RUN1, S_RUN2: begin
                    mask_q <= mask_q | wr_mask;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (!mask_full && timeout) begin
                        error_q <= 1'b1;
                    end
                    if (state_q == S_RUN2 && mask_full) begin
                        ready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_hit) begin
            store[wr_idx] <= i_ks_subkey;
        end
    end

    // Round-robin arbiter: rr_q names the requester with priority this cycle.
    always_comb begin
        gnt = 2'b00;
        if (ready_q && state_q == S_IDLE) begin
            if (!rr_q) begin
                if (i_req[0])      gnt = 2'b01;
                else if (i_req[1]) gnt = 2'b10;
            end else begin
                if (i_req[1])      gnt = 2'b10;
                else if (i_req[0]) gnt = 2'b01;
            end
        end
        rd_sub      = gnt[1] ? i_req_idx1 : i_req_idx0;
        rd_in_range = ({1'b0, rd_sub} < 7'(NUM_SUBKEYS));
        rd_idx      = '0;
        if (rd_in_range) begin
            rd_idx = (gnt[1] ? 7'(NUM_SUBKEYS) : 7'd0) + {1'b0, rd_sub};
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rr_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= |gnt;
            if (gnt[0]) rr_q <= 1'b1;
            if (gnt[1]) rr_q <= 1'b0;
            if (|gnt) begin
                rd_id_q   <= gnt[1];
                rd_data_q <= rd_in_range ? store[rd_idx] : '0;
            end
        end
    end

    assign o_busy       = (state_q != S_IDLE);
    assign o_keys_ready = ready_q;
    assign o_error      = error_q;
    assign o_ks_begin   = (state_q == S_START1) || (state_q == S_START2);
    assign o_ks_key     = ((state_q == S_START1) || (state_q == S_RUN1)) ? key1_q :
                          ((state_q == S_START2) || (state_q == S_RUN2)) ? key2_q : '0;
    assign o_gnt        = gnt;
    assign o_rd_valid   = rd_valid_q;
    assign o_rd_data    = rd_data_q;
    assign o_rd_id      = rd_id_q;

endmodule

// File: tb/tb_serpent_key_manager.sv
module tb_serpent_key_manager;
    localparam int unsigned NSK = 33;
    localparam int unsigned TMO = 64;

    logic         i_clk = 1'b0;
    logic         i_rstn = 1'b0;
    logic         i_load = 1'b0;
    logic [255:0] i_key1 = '0;
    logic [255:0] i_key2 = '0;
    logic         o_busy, o_keys_ready, o_error, o_ks_begin;
    logic [255:0] o_ks_key;
    logic [127:0] i_ks_subkey = '0;
    logic [5:0]   i_ks_address = '0;
    logic         i_ks_subkey_valid = 1'b0;
    logic [1:0]   i_req = '0;
    logic [5:0]   i_req_idx0 = '0;
    logic [5:0]   i_req_idx1 = '0;
    logic [1:0]   o_gnt;
    logic         o_rd_valid;
    logic [127:0] o_rd_data;
    logic         o_rd_id;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: expected store contents, arbiter priority, pending read
    logic [127:0] exp_store [2*NSK];
    int           ptr = 0;
    bit           exp_rd_pend = 1'b0;
    logic [127:0] exp_rd_data = '0;
    logic         exp_rd_id = 1'b0;

    serpent_key_manager #(.NUM_SUBKEYS(NSK), .KS_TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_load(i_load),
        .i_key1(i_key1), .i_key2(i_key2),
        .o_busy(o_busy), .o_keys_ready(o_keys_ready), .o_error(o_error),
        .o_ks_begin(o_ks_begin), .o_ks_key(o_ks_key),
        .i_ks_subkey(i_ks_subkey), .i_ks_address(i_ks_address),
        .i_ks_subkey_valid(i_ks_subkey_valid),
        .i_req(i_req), .i_req_idx0(i_req_idx0), .i_req_idx1(i_req_idx1),
        .o_gnt(o_gnt), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_rd_id(o_rd_id)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load_keys(input logic [255:0] k1, input logic [255:0] k2);
        i_key1 = k1;
        i_key2 = k2;
        i_load = 1'b1;
        step();
        i_load = 1'b0;
    endtask

    task automatic test_no_grants(input int n);
        i_req = 2'b11;
        i_req_idx0 = 6'd0;
        i_req_idx1 = 6'd0;
        for (int i = 0; i < n; i++) begin
            #1;
            vectors++;
            if (o_gnt !== 2'b00 || o_rd_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL no_grant: gnt=%b rd_valid=%b required gnt=00 rd_valid=0", o_gnt, o_rd_valid);
            end
            step();
        end
        i_req = 2'b00;
    endtask

    // Plays the schedule datapath for one pass.
    // mode 0: in order, data={key[31:0],addr}; 1: reversed with dup 5 and stray 40;
    // 2: stop after 10 subkeys; 3: in order, random data.
    task automatic run_pass(input logic [255:0] key, input int bank, input int mode, input bit mid_load);
        int addrs[$];
        bit found = 1'b0;
        logic [127:0] d;
        logic [5:0] a6;
        for (int i = 0; i < 10; i++) begin
            if (o_ks_begin === 1'b1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL ks_begin: no start pulse within 10 cycles (bank %0d)", bank);
        end
        vectors++;
        if (o_ks_key !== key || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ks_key_at_begin: key=%h busy=%b required key=%h busy=1", o_ks_key, o_busy, key);
        end
        case (mode)
            1: begin
                for (int a = 32; a >= 6; a--) addrs.push_back(a);
                addrs.push_back(5);
                addrs.push_back(40);
                addrs.push_back(5);
                for (int a = 4; a >= 0; a--) addrs.push_back(a);
            end
            2: for (int a = 0; a < 10; a++) addrs.push_back(a);
            default: for (int a = 0; a < 33; a++) addrs.push_back(a);
        endcase
        step();
        for (int k = 0; k < addrs.size(); k++) begin
            a6 = 6'(addrs[k]);
            d = (mode == 0) ? 128'({key[31:0], a6}) : rand128();
            if (addrs[k] < NSK) exp_store[bank*NSK + addrs[k]] = d;
            i_ks_subkey_valid = 1'b1;
            i_ks_address = a6;
            i_ks_subkey = d;
            i_req = 2'b11;
            if (mid_load && k == 10) begin
                i_load = 1'b1;
                i_key1 = rand256();
                i_key2 = rand256();
            end
            #1;
            vectors++;
            if (o_ks_key !== key || o_busy !== 1'b1 || o_gnt !== 2'b00) begin
                miscompares++;
                $display("FAIL pass_hold: key=%h busy=%b gnt=%b required key=%h busy=1 gnt=00",
                         o_ks_key, o_busy, o_gnt, key);
            end
            step();
            i_ks_subkey_valid = 1'b0;
            i_load = 1'b0;
            i_req = 2'b00;
            if (mode != 2) begin
                vectors++;
                if (k != addrs.size() - 1) begin
                    if (o_ks_begin !== 1'b0 || o_keys_ready !== 1'b0 || o_busy !== 1'b1) begin
                        miscompares++;
                        $display("FAIL pass_early_end: begin=%b ready=%b busy=%b at write %0d required 0,0,1",
                                 o_ks_begin, o_keys_ready, o_busy, k);
                    end
                end else if (bank == 0) begin
                    if (o_ks_begin !== 1'b1 || o_busy !== 1'b1) begin
                        miscompares++;
                        $display("FAIL pass1_to_start2: begin=%b busy=%b required 1,1", o_ks_begin, o_busy);
                    end
                end else begin
                    if (o_keys_ready !== 1'b1 || o_busy !== 1'b0) begin
                        miscompares++;
                        $display("FAIL ready_after_last: ready=%b busy=%b required 1,0", o_keys_ready, o_busy);
                    end
                end
            end
        end
    endtask

    // mode 0: both requesters held with fixed indices; otherwise random requests.
    task automatic do_reads(input int n, input int mode, input logic [5:0] f0, input logic [5:0] f1);
        bit pend[2];
        logic [5:0] pidx[2];
        logic [1:0] eg;
        int g;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        pidx[0] = '0;
        pidx[1] = '0;
        for (int c = 0; c < n; c++) begin
            vectors++;
            if (o_rd_valid !== exp_rd_pend ||
                (exp_rd_pend && (o_rd_data !== exp_rd_data || o_rd_id !== exp_rd_id))) begin
                miscompares++;
                $display("FAIL rd_return: valid=%b id=%b data=%h required valid=%b id=%b data=%h",
                         o_rd_valid, o_rd_id, o_rd_data, exp_rd_pend, exp_rd_id, exp_rd_data);
            end
            for (int r = 0; r < 2; r++) begin
                if (!pend[r]) begin
                    if (mode == 0) begin
                        pend[r] = 1'b1;
                        pidx[r] = (r == 1) ? f1 : f0;
                    end else if ($urandom_range(0, 2) != 0) begin
                        pend[r] = 1'b1;
                        pidx[r] = 6'($urandom_range(0, 40));
                    end
                end
            end
            i_req = {pend[1], pend[0]};
            i_req_idx0 = pidx[0];
            i_req_idx1 = pidx[1];
            #1;
            eg = 2'b00;
            if (pend[ptr]) eg[ptr] = 1'b1;
            else if (pend[1-ptr]) eg[1-ptr] = 1'b1;
            vectors++;
            if (o_gnt !== eg) begin
                miscompares++;
                $display("FAIL gnt: got %b required %b (req=%b)", o_gnt, eg, i_req);
            end
            if (eg != 2'b00) begin
                g = eg[1] ? 1 : 0;
                exp_rd_pend = 1'b1;
                exp_rd_data = (pidx[g] < NSK) ? exp_store[g*NSK + pidx[g]] : '0;
                exp_rd_id = eg[1];
                pend[g] = 1'b0;
                ptr = 1 - g;
            end else begin
                exp_rd_pend = 1'b0;
            end
            step();
        end
        i_req = 2'b00;
        vectors++;
        if (o_rd_valid !== exp_rd_pend ||
            (exp_rd_pend && (o_rd_data !== exp_rd_data || o_rd_id !== exp_rd_id))) begin
            miscompares++;
            $display("FAIL rd_return_last: valid=%b id=%b data=%h required valid=%b id=%b data=%h",
                     o_rd_valid, o_rd_id, o_rd_data, exp_rd_pend, exp_rd_id, exp_rd_data);
        end
        exp_rd_pend = 1'b0;
        step();
        vectors++;
        if (o_rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_idle: valid=%b required 0", o_rd_valid);
        end
    endtask

    task automatic test_reset();
        i_rstn = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        vectors++;
        if ({o_busy, o_keys_ready, o_error, o_ks_begin, o_ks_key, o_gnt, o_rd_valid, o_rd_data, o_rd_id} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b ready=%b err=%b begin=%b gnt=%b rd_valid=%b id=%b required all 0",
                     o_busy, o_keys_ready, o_error, o_ks_begin, o_gnt, o_rd_valid, o_rd_id);
        end
        i_rstn = 1'b1;
        ptr = 0;
        exp_rd_pend = 1'b0;
        step();
        test_no_grants(3);
    endtask

    task automatic test_load_in_order();
        load_keys(256'd1, 256'd2);
        run_pass(256'd1, 0, 0, 1'b0);
        run_pass(256'd2, 1, 0, 1'b0);
    endtask

    task automatic test_reads();
        do_reads(12, 0, 6'd0, 6'd32);
        do_reads(40, 1, 6'd0, 6'd0);
    endtask

    task automatic test_out_of_order();
        logic [255:0] k1, k2;
        k1 = rand256();
        k2 = rand256();
        load_keys(k1, k2);
        run_pass(k1, 0, 1, 1'b0);
        run_pass(k2, 1, 1, 1'b0);
        do_reads(6, 0, 6'd5, 6'd5);
        do_reads(40, 1, 6'd0, 6'd0);
    endtask

    task automatic test_timeout();
        logic [255:0] k1, k2;
        int cycles;
        k1 = rand256();
        k2 = rand256();
        load_keys(k1, k2);
        run_pass(k1, 0, 2, 1'b0);
        cycles = 11;
        while (o_error !== 1'b1 && cycles < 200) begin
            step();
            cycles++;
        end
        vectors++;
        if (o_error !== 1'b1 || cycles != TMO + 1) begin
            miscompares++;
            $display("FAIL timeout: error=%b after %0d cycles required error=1 after %0d", o_error, cycles, TMO + 1);
        end
        vectors++;
        if (o_keys_ready !== 1'b0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_state: ready=%b busy=%b required 0,0", o_keys_ready, o_busy);
        end
        test_no_grants(5);
        k1 = rand256();
        k2 = rand256();
        load_keys(k1, k2);
        vectors++;
        if (o_error !== 1'b0 || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL error_clear: error=%b busy=%b required 0,1", o_error, o_busy);
        end
        run_pass(k1, 0, 3, 1'b0);
        run_pass(k2, 1, 3, 1'b0);
        do_reads(30, 1, 6'd0, 6'd0);
    endtask

    task automatic test_reload();
        logic [255:0] k1, k2;
        logic [127:0] old3;
        k1 = rand256();
        k2 = rand256();
        load_keys(k1, k2);
        run_pass(k1, 0, 3, 1'b0);
        run_pass(k2, 1, 3, 1'b1);
        do_reads(20, 1, 6'd0, 6'd0);
        old3 = exp_store[3];
        k1 = rand256();
        k2 = rand256();
        i_key1 = k1;
        i_key2 = k2;
        i_load = 1'b1;
        i_req = 2'b01;
        i_req_idx0 = 6'd3;
        #1;
        vectors++;
        if (o_gnt !== 2'b01) begin
            miscompares++;
            $display("FAIL gnt_at_reload: got %b required 01", o_gnt);
        end
        ptr = 1;
        step();
        i_load = 1'b0;
        i_req = 2'b00;
        vectors++;
        if (o_rd_valid !== 1'b1 || o_rd_data !== old3 || o_rd_id !== 1'b0 || o_keys_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL read_across_reload: valid=%b id=%b data=%h ready=%b required 1,0,%h,0",
                     o_rd_valid, o_rd_id, o_rd_data, o_keys_ready, old3);
        end
        run_pass(k1, 0, 3, 1'b0);
        run_pass(k2, 1, 3, 1'b0);
        do_reads(30, 1, 6'd0, 6'd0);
    endtask

    task automatic test_reset_mid_run();
        logic [255:0] k1, k2;
        k1 = rand256();
        k2 = rand256();
        load_keys(k1, k2);
        run_pass(k1, 0, 3, 1'b0);
        run_pass(k2, 1, 2, 1'b0);
        i_req = 2'b11;
        i_ks_subkey_valid = 1'b1;
        i_rstn = 1'b0;
        #1;
        vectors++;
        if ({o_busy, o_keys_ready, o_error, o_ks_begin, o_ks_key, o_gnt, o_rd_valid, o_rd_data, o_rd_id} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_run: busy=%b ready=%b err=%b begin=%b gnt=%b rd_valid=%b required all 0",
                     o_busy, o_keys_ready, o_error, o_ks_begin, o_gnt, o_rd_valid);
        end
        i_ks_subkey_valid = 1'b0;
        step();
        step();
        i_rstn = 1'b1;
        ptr = 0;
        exp_rd_pend = 1'b0;
        step();
        test_no_grants(5);
        k1 = rand256();
        k2 = rand256();
        load_keys(k1, k2);
        run_pass(k1, 0, 3, 1'b0);
        run_pass(k2, 1, 3, 1'b0);
        do_reads(12, 0, 6'd0, 6'd32);
    endtask

    initial begin
        test_reset();
        test_load_in_order();
        test_reads();
        test_out_of_order();
        test_timeout();
        test_reload();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
